// File: rtl/ext_alu_sched_pkg.sv
// Shared CPU definitions for the extended-ALU scheduler: alu_func codes,
// scheduler FSM states and register/func widths.
package ext_alu_sched_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned FUNC_W = 3;

  typedef enum logic [FUNC_W-1:0] {
    ALU_MUL  = 3'd0,
    ALU_UMUL = 3'd1,
    ALU_ADDF = 3'd2,
    ALU_SUBF = 3'd3,
    ALU_MULF = 3'd4,
    ALU_ITF  = 3'd5,
    ALU_FTI  = 3'd6
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/ext_raw_chk.sv
// Read-after-write check: two enabled sources against one destination.
// Register 0 is hardwired and never produces a hazard.
module ext_raw_chk
  import ext_alu_sched_pkg::*;
(
  input  logic [4:0] rs0,
  input  logic       re0,
  input  logic [4:0] rs1,
  input  logic       re1,
  input  logic [4:0] dst,
  output logic       hit
);

  always_comb begin
    hit = 1'b0;
    if (dst != REG_W'(0)) begin
      hit = (re0 && (rs0 == dst)) || (re1 && (rs1 == dst));
    end
  end

endmodule

// File: rtl/ext_alu_sched.sv
// Dual-slot decode scheduler for a single shared extended ALU: grants one
// ext op at a time, tracks it through execution and writeback, raises stalls.
module ext_alu_sched
  import ext_alu_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_ext,
  input  logic       s1_ext,
  input  logic [2:0] s0_func,
  input  logic [2:0] s1_func,
  input  logic [4:0] s0_dst,
  input  logic [4:0] s1_dst,
  input  logic [4:0] s0_rs0,
  input  logic [4:0] s0_rs1,
  input  logic [4:0] s1_rs0,
  input  logic [4:0] s1_rs1,
  input  logic       s0_re0,
  input  logic       s0_re1,
  input  logic       s1_re0,
  input  logic       s1_re1,
  input  logic       flush,
  input  logic       eu_done,
  input  logic       wb_ack,
  output logic       s0_stall,
  output logic       s1_stall,
  output logic       eu_start,
  output logic [2:0] eu_func,
  output logic       eu_sel,
  output logic       wb_valid,
  output logic [4:0] wb_dst,
  output logic       busy
);

  sched_state_e     state_q, state_d;
  logic             eu_start_q, eu_start_d;
  alu_func_e        eu_func_q, eu_func_d;
  logic             eu_sel_q, eu_sel_d;
  logic [REG_W-1:0] wb_dst_q, wb_dst_d;

  logic hit0, hit1, hit1_s0;
  logic busy_c, raw0_c, raw1_c, grant_ok_c, grant0_c, grant1_c;
  logic s0_stall_c, s1_stall_c;

  // Each slot against the in-flight destination, plus slot1 against slot0.
  ext_raw_chk u_raw_s0 (
    .rs0 (s0_rs0), .re0 (s0_re0), .rs1 (s0_rs1), .re1 (s0_re1),
    .dst (wb_dst_q), .hit (hit0)
  );

  ext_raw_chk u_raw_s1 (
    .rs0 (s1_rs0), .re0 (s1_re0), .rs1 (s1_rs1), .re1 (s1_re1),
    .dst (wb_dst_q), .hit (hit1)
  );

  ext_raw_chk u_raw_s1_s0 (
    .rs0 (s1_rs0), .re0 (s1_re0), .rs1 (s1_rs1), .re1 (s1_re1),
    .dst (s0_dst), .hit (hit1_s0)
  );

  // Grant and stall decisions; the unit is free in IDLE or in an acked WB.
  always_comb begin
    busy_c     = (state_q != ST_IDLE);
    raw0_c     = busy_c && hit0;
    raw1_c     = busy_c && hit1;
    grant_ok_c = !flush && ((state_q == ST_IDLE) || ((state_q == ST_WB) && wb_ack));
    grant0_c   = grant_ok_c && s0_ext && !raw0_c;
    s0_stall_c = raw0_c || (s0_ext && !grant0_c);
    grant1_c   = grant_ok_c && !s0_ext && s1_ext && !raw1_c && !s0_stall_c;
    s1_stall_c = s0_stall_c || raw1_c || (grant0_c && hit1_s0) ||
                 (s1_ext && !grant1_c);
  end

  always_comb begin
    state_d    = state_q;
    eu_start_d = 1'b0;
    eu_func_d  = eu_func_q;
    eu_sel_d   = eu_sel_q;
    wb_dst_d   = wb_dst_q;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_EXEC: if (eu_done) state_d = ST_WB;
      ST_WB:   if (wb_ack)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (grant0_c || grant1_c) begin
      state_d    = ST_EXEC;
      eu_start_d = 1'b1;
      eu_sel_d   = grant1_c;
      eu_func_d  = grant0_c ? alu_func_e'(s0_func) : alu_func_e'(s1_func);
      wb_dst_d   = grant0_c ? s0_dst : s1_dst;
    end

    // Flush abandons the in-flight op; grants are already blocked above.
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      eu_start_q <= 1'b0;
      eu_func_q  <= ALU_MUL;
      eu_sel_q   <= 1'b0;
      wb_dst_q   <= '0;
    end else begin
      state_q    <= state_d;
      eu_start_q <= eu_start_d;
      eu_func_q  <= eu_func_d;
      eu_sel_q   <= eu_sel_d;
      wb_dst_q   <= wb_dst_d;
    end
  end

  assign s0_stall = s0_stall_c;
  assign s1_stall = s1_stall_c;
  assign eu_start = eu_start_q;
  assign eu_func  = eu_func_q;
  assign eu_sel   = eu_sel_q;
  assign wb_valid = (state_q == ST_WB);
  assign wb_dst   = wb_dst_q;
  assign busy     = busy_c;

endmodule

// File: tb/tb_ext_alu_sched.sv
// Directed and random stimulus for ext_alu_sched, checked against an
// op-tracking reference model.
module tb_ext_alu_sched;
  import ext_alu_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       s0_ext, s1_ext;
  logic [2:0] s0_func, s1_func;
  logic [4:0] s0_dst, s1_dst, s0_rs0, s0_rs1, s1_rs0, s1_rs1;
  logic       s0_re0, s0_re1, s1_re0, s1_re1;
  logic       flush, eu_done, wb_ack;
  logic       s0_stall, s1_stall, eu_start, eu_sel, wb_valid, busy;
  logic [2:0] eu_func;
  logic [4:0] wb_dst;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: an op is either executing (m_pend) or holding a result (m_res).
  bit         m_pend, m_res, m_start, m_sel;
  logic [2:0] m_func;
  logic [4:0] m_dst;
  bit         e_s0, e_s1, e_g0, e_g1;

  ext_alu_sched dut (
    .clk(clk), .rst(rst),
    .s0_ext(s0_ext), .s1_ext(s1_ext), .s0_func(s0_func), .s1_func(s1_func),
    .s0_dst(s0_dst), .s1_dst(s1_dst),
    .s0_rs0(s0_rs0), .s0_rs1(s0_rs1), .s1_rs0(s1_rs0), .s1_rs1(s1_rs1),
    .s0_re0(s0_re0), .s0_re1(s0_re1), .s1_re0(s1_re0), .s1_re1(s1_re1),
    .flush(flush), .eu_done(eu_done), .wb_ack(wb_ack),
    .s0_stall(s0_stall), .s1_stall(s1_stall), .eu_start(eu_start),
    .eu_func(eu_func), .eu_sel(eu_sel), .wb_valid(wb_valid),
    .wb_dst(wb_dst), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit reads(logic [4:0] a, logic ea, logic [4:0] b, logic eb,
                               logic [4:0] d);
    if (d == 5'd0) return 1'b0;
    return (ea && a == d) || (eb && b == d);
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    s0_ext = 0; s1_ext = 0; s0_func = 0; s1_func = 0; s0_dst = 0; s1_dst = 0;
    s0_rs0 = 0; s0_rs1 = 0; s1_rs0 = 0; s1_rs1 = 0;
    s0_re0 = 0; s0_re1 = 0; s1_re0 = 0; s1_re1 = 0;
    flush = 0; eu_done = 0; wb_ack = 0;
  endtask

  task automatic model_reset();
    m_pend = 0; m_res = 0; m_start = 0; m_sel = 0; m_func = 0; m_dst = 0;
  endtask

  // Expected stalls and grants for the current inputs.
  task automatic predict();
    bit occupied, free, h0, h1;
    occupied = m_pend || m_res;
    free     = !flush && !m_pend && (!m_res || wb_ack);
    h0 = occupied && reads(s0_rs0, s0_re0, s0_rs1, s0_re1, m_dst);
    h1 = occupied && reads(s1_rs0, s1_re0, s1_rs1, s1_re1, m_dst);
    e_g0 = free && s0_ext && !h0;
    e_s0 = h0 || (s0_ext && !e_g0);
    e_g1 = free && !s0_ext && s1_ext && !h1 && !e_s0;
    e_s1 = e_s0 || h1 || (s1_ext && !e_g1) ||
           (e_g0 && reads(s1_rs0, s1_re0, s1_rs1, s1_re1, s0_dst));
  endtask

  task automatic check_stalls();
    predict();
    chk("s0_stall", 8'(s0_stall), 8'(e_s0));
    chk("s1_stall", 8'(s1_stall), 8'(e_s1));
  endtask

  task automatic check_outs();
    chk("eu_start", 8'(eu_start), 8'(m_start));
    chk("eu_func",  8'(eu_func),  8'(m_func));
    chk("eu_sel",   8'(eu_sel),   8'(m_sel));
    chk("wb_valid", 8'(wb_valid), 8'(m_res));
    chk("wb_dst",   8'(wb_dst),   8'(m_dst));
    chk("busy",     8'(busy),     8'(m_pend || m_res));
  endtask

  // One clock: inputs already driven at the preceding negedge.
  task automatic step();
    #1;
    check_stalls();
    @(posedge clk);
    m_start = e_g0 || e_g1;
    if (e_g0 || e_g1) begin
      m_pend = 1; m_res = 0; m_sel = e_g1;
      m_func = e_g0 ? s0_func : s1_func;
      m_dst  = e_g0 ? s0_dst  : s1_dst;
    end else if (flush) begin
      m_pend = 0; m_res = 0;
    end else if (m_pend && eu_done) begin
      m_pend = 0; m_res = 1;
    end else if (m_res && wb_ack) begin
      m_res = 0;
    end
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int n_busy, n_wbv, n_start;

  initial begin
    clear_in();
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_outs();
    // Stalls during reset: slot0 granted-looking, slot1 ext and reading r9.
    s0_ext = 1; s0_dst = 5'd9; s1_ext = 1; s1_rs0 = 5'd9; s1_re0 = 1;
    #1;
    check_stalls();
    chk("rst_s1_stall", 8'(s1_stall), 8'd1);
    chk("rst_s0_stall", 8'(s0_stall), 8'd0);
    @(negedge clk);
    clear_in();
    rst = 1'b0;

    // Single MUL to r5: done three cycles after grant, ack in the next cycle.
    n_busy = 0; n_wbv = 0; n_start = 0;
    for (int c = 0; c < 6; c++) begin
      clear_in();
      if (c == 0) begin s0_ext = 1; s0_func = ALU_MUL; s0_dst = 5'd5; end
      if (c == 3) eu_done = 1;
      if (c == 4) wb_ack = 1;
      step();
      n_busy  += int'(busy);
      n_wbv   += int'(wb_valid);
      n_start += int'(eu_start);
      if (wb_valid) chk("mul_wb_dst", 8'(wb_dst), 8'd5);
    end
    chk("mul_busy_cycles", 8'(n_busy), 8'd4);
    chk("mul_wbv_cycles", 8'(n_wbv), 8'd1);
    chk("mul_start_cycles", 8'(n_start), 8'd1);

    // Both slots ext: slot0 first, slot1 issues back-to-back on slot0's ack.
    clear_in();
    s0_ext = 1; s0_func = ALU_UMUL; s0_dst = 5'd3;
    s1_ext = 1; s1_func = ALU_SUBF; s1_dst = 5'd4;
    #1;
    chk("both_s1_stall", 8'(s1_stall), 8'd1);
    step();
    chk("both_eu_sel", 8'(eu_sel), 8'd0);
    s0_ext = 0;
    step();
    eu_done = 1; step(); eu_done = 0;
    wb_ack = 1;
    #1;
    chk("b2b_s1_stall", 8'(s1_stall), 8'd0);
    step();
    chk("b2b_eu_sel", 8'(eu_sel), 8'd1);
    chk("b2b_eu_start", 8'(eu_start), 8'd1);
    clear_in();
    eu_done = 1; step();
    clear_in(); wb_ack = 1; step();
    clear_in(); step();

    // RAW on r7 held while busy; a dst of r0 never hazards.
    s0_ext = 1; s0_func = ALU_MULF; s0_dst = 5'd7; step();
    clear_in(); s0_rs1 = 5'd7; s0_re1 = 1;
    step(); step();
    chk("raw7_s0_stall", 8'(s0_stall), 8'd1);
    chk("raw7_s1_stall", 8'(s1_stall), 8'd1);
    eu_done = 1; step(); eu_done = 0;
    step();
    wb_ack = 1; step(); wb_ack = 0;
    step();
    chk("raw7_clear", 8'(s0_stall), 8'd0);
    clear_in(); s0_ext = 1; s0_func = ALU_ITF; s0_dst = 5'd0; step();
    clear_in(); s0_rs0 = 5'd0; s0_re0 = 1; s0_rs1 = 5'd0; s0_re1 = 1;
    step();
    chk("raw0_no_stall", 8'(s0_stall), 8'd0);
    eu_done = 1; step(); clear_in(); wb_ack = 1; step(); clear_in();

    // Ack plus new ADDF in the same cycle issues with zero bubble.
    s0_ext = 1; s0_func = ALU_FTI; s0_dst = 5'd2; step();
    clear_in(); eu_done = 1; step();
    clear_in(); wb_ack = 1; s0_ext = 1; s0_func = ALU_ADDF; s0_dst = 5'd6; step();
    chk("b2b_addf_func", 8'(eu_func), 8'(ALU_ADDF));
    chk("b2b_addf_busy", 8'(busy), 8'd1);
    clear_in(); eu_done = 1; step(); clear_in(); wb_ack = 1; step(); clear_in();

    // Flush during EXEC, then a late eu_done: no writeback.
    s0_ext = 1; s0_func = ALU_MUL; s0_dst = 5'd11; step();
    clear_in(); flush = 1; s1_ext = 1; step();
    clear_in(); eu_done = 1; step();
    clear_in(); step();
    chk("flush_no_wb", 8'(wb_valid), 8'd0);
    chk("flush_idle", 8'(busy), 8'd0);

    // Reset while holding a result in WB.
    s0_ext = 1; s0_func = ALU_SUBF; s0_dst = 5'd13; step();
    clear_in(); eu_done = 1; step(); clear_in();
    chk("pre_rst_wb", 8'(wb_valid), 8'd1);
    do_reset();
    step();

    // Random traffic over a small register range to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      s0_ext  = ($urandom_range(0, 9) < 3);
      s1_ext  = ($urandom_range(0, 9) < 3);
      s0_func = 3'($urandom_range(0, 6));
      s1_func = 3'($urandom_range(0, 6));
      s0_dst  = 5'($urandom_range(0, 3));
      s1_dst  = 5'($urandom_range(0, 3));
      s0_rs0  = 5'($urandom_range(0, 3));
      s0_rs1  = 5'($urandom_range(0, 3));
      s1_rs0  = 5'($urandom_range(0, 3));
      s1_rs1  = 5'($urandom_range(0, 3));
      s0_re0  = 1'($urandom_range(0, 1));
      s0_re1  = 1'($urandom_range(0, 1));
      s1_re0  = 1'($urandom_range(0, 1));
      s1_re1  = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 19) == 0);
      eu_done = ($urandom_range(0, 9) < 4);
      wb_ack  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
